vga_tx: RTL and testbench

VGA_TX -- requirements
Module: vga_tx

---
 rtl/vga_tx.sv | 140 ++++++++++++++
 tb/tb_vga_tx.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/vga_tx.sv
// vga_tx: VGA raster timing generator with a ready/valid pixel source and registered video outputs
//
// Ports:
//   pixel_clk     sole clock
//   rst_n         asynchronous active-low reset; its release is synchronised internally
//   en            run enable; low returns to IDLE and abandons the frame
//   pix_data      source pixel {r,g,b}
//   pix_valid     pix_data is valid
//   pix_ready     pixel consumed this cycle (active area while running)
//   underrun_clr  clears the sticky underrun flag (a same-cycle set wins)
//   r, g, b       registered pixel colour, zero outside active video or on a missing pixel
//   hsync, vsync  registered syncs, active low
//   de            registered active-video flag
//   sof           one-cycle start-of-frame pulse, aligned with pixel (0,0)
//   underrun      sticky flag: a pixel was missing during active video
module vga_tx #(
    parameter int HOR_ACT   = 640,
    parameter int HOR_FP    = 16,
    parameter int HOR_SYNC  = 96,
    parameter int HOR_BP    = 48,
    parameter int VERT_ACT  = 480,
    parameter int VERT_FP   = 11,
    parameter int VERT_SYNC = 2,
    parameter int VERT_BP   = 31
) (
    input  logic        pixel_clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [23:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic        underrun_clr,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        sof,
    output logic        underrun
);
    localparam int HTOTAL = HOR_ACT + HOR_FP + HOR_SYNC + HOR_BP;
    localparam int VTOTAL = VERT_ACT + VERT_FP + VERT_SYNC + VERT_BP;
    localparam logic [10:0] H_ACT  = 11'(HOR_ACT);
    localparam logic [10:0] H_SS   = 11'(HOR_ACT + HOR_FP);
    localparam logic [10:0] H_SE   = 11'(HOR_ACT + HOR_FP + HOR_SYNC);
    localparam logic [10:0] H_LAST = 11'(HTOTAL - 1);
    localparam logic [9:0]  V_ACT  = 10'(VERT_ACT);
    localparam logic [9:0]  V_SS   = 10'(VERT_ACT + VERT_FP);
    localparam logic [9:0]  V_SE   = 10'(VERT_ACT + VERT_FP + VERT_SYNC);
    localparam logic [9:0]  V_LAST = 10'(VTOTAL - 1);

    if (HTOTAL > 2047 || VTOTAL > 1023) begin : g_bad_timing
        $error("vga_tx: timing totals exceed the 11-bit/10-bit counter range");
    end

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_d;
    logic [1:0]  sync_q;
    logic [10:0] h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic [23:0] rgb_q, rgb_d;
    logic        hsync_q, hsync_d, vsync_q, vsync_d;
    logic        de_q, de_d, sof_q, sof_d, underrun_q, underrun_d;
    logic        run, rst_ok, h_wrap, v_wrap;

    // two-flop release synchroniser: RUN cannot start until the release has been seen on two edges
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[0], 1'b1};
    end

    assign rst_ok = sync_q[1];

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = (en && rst_ok) ? RUN : IDLE;
    end

    always_comb begin
        run       = (state_q == RUN);
        pix_ready = run && (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    end

    assign h_wrap = (h_cnt_q == H_LAST);
    assign v_wrap = (v_cnt_q == V_LAST);

    // counters sit at zero whenever not running, so entering RUN always starts at (0,0)
    always_comb begin
        h_cnt_d    = '0;
        v_cnt_d    = '0;
        if (run && en) begin
            h_cnt_d = h_wrap ? '0 : h_cnt_q + 11'd1;
            v_cnt_d = h_wrap ? (v_wrap ? '0 : v_cnt_q + 10'd1) : v_cnt_q;
        end
    end

    always_comb begin
        rgb_d      = (pix_ready && pix_valid) ? pix_data : '0;
        de_d       = pix_ready;
        hsync_d    = ~(run && h_cnt_q >= H_SS && h_cnt_q < H_SE);
        vsync_d    = ~(run && v_cnt_q >= V_SS && v_cnt_q < V_SE);
        sof_d      = run && h_cnt_q == '0 && v_cnt_q == '0;
        underrun_d = (pix_ready && !pix_valid) || (underrun_q && !underrun_clr);
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            rgb_q      <= '0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            de_q       <= 1'b0;
            sof_q      <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            rgb_q      <= rgb_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            de_q       <= de_d;
            sof_q      <= sof_d;
            underrun_q <= underrun_d;
        end
    end

    assign {r, g, b} = rgb_q;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign de        = de_q;
    assign sof       = sof_q;
    assign underrun  = underrun_q;
endmodule

// File: tb/tb_vga_tx.sv
// tb_vga_tx: scoreboard bench for vga_tx using a reduced raster
module tb_vga_tx;
    localparam int HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    typedef struct packed {
        logic        de;
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
        logic        sof;
        logic        und;
    } exp_t;

    logic        pixel_clk = 1'b0;
    logic        rst_n = 1'b0, en = 1'b0, pix_valid = 1'b0, underrun_clr = 1'b0;
    logic [23:0] pix_data = '0;
    logic        pix_ready, hsync, vsync, de, sof, underrun;
    logic [7:0]  r, g, b;

    int          checks = 0, failures = 0;
    int          m_h = 0, m_v = 0, m_sync = 0, cyc = 0;
    logic        m_run = 1'b0, m_und = 1'b0;
    logic [23:0] m_n = '0;
    exp_t        sb[$];

    vga_tx #(
        .HOR_ACT(HA), .HOR_FP(HF), .HOR_SYNC(HS), .HOR_BP(HB),
        .VERT_ACT(VA), .VERT_FP(VF), .VERT_SYNC(VS), .VERT_BP(VB)
    ) dut (
        .pixel_clk(pixel_clk), .rst_n(rst_n), .en(en),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .underrun_clr(underrun_clr), .r(r), .g(g), .b(b),
        .hsync(hsync), .vsync(vsync), .de(de), .sof(sof), .underrun(underrun)
    );

    always #5 pixel_clk = ~pixel_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic e, input logic v, input logic c);
        exp_t x;
        logic rdy;
        @(negedge pixel_clk);
        en = e;
        pix_valid = v;
        underrun_clr = c;
        pix_data = m_n;
        rdy = m_run && m_h < HA && m_v < VA;
        #1 chk("pix_ready", 32'(pix_ready), 32'(rdy));
        x.de  = rdy;
        x.rgb = (rdy && v) ? m_n : 24'd0;
        x.hs  = !(m_run && m_h >= HA + HF && m_h < HA + HF + HS);
        x.vs  = !(m_run && m_v >= VA + VF && m_v < VA + VF + VS);
        x.sof = m_run && m_h == 0 && m_v == 0;
        x.und = (rdy && !v) || (m_und && !c);
        sb.push_back(x);
        @(posedge pixel_clk);
        if (rdy && v) m_n++;
        m_und = x.und;
        if (m_run && e) begin
            if (m_h == HT - 1) begin
                m_h = 0;
                m_v = (m_v == VT - 1) ? 0 : m_v + 1;
            end else m_h++;
        end else begin
            m_h = 0;
            m_v = 0;
        end
        m_run = e && m_sync == 2;
        if (m_sync < 2) m_sync++;
        cyc++;
        #1 x = sb.pop_front();
        chk("de", 32'(de), 32'(x.de));
        chk("rgb", 32'({r, g, b}), 32'(x.rgb));
        chk("hsync", 32'(hsync), 32'(x.hs));
        chk("vsync", 32'(vsync), 32'(x.vs));
        chk("sof", 32'(sof), 32'(x.sof));
        chk("underrun", 32'(underrun), 32'(x.und));
    endtask

    task automatic run_to(input int h, input int v);
        int n = 0;
        while (!(m_h == h && m_v == v) && n < 4 * HT * VT) begin
            step(1'b1, 1'b1, 1'b0);
            n++;
        end
        if (n == 4 * HT * VT) chk("run_to_timeout", 32'(m_h), 32'(h));
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_hsync"}, 32'(hsync), 32'd1);
        chk({tag, "_vsync"}, 32'(vsync), 32'd1);
        chk({tag, "_de"}, 32'(de), 32'd0);
        chk({tag, "_sof"}, 32'(sof), 32'd0);
        chk({tag, "_und"}, 32'(underrun), 32'd0);
        chk({tag, "_rgb"}, 32'({r, g, b}), 32'd0);
        chk({tag, "_ready"}, 32'(pix_ready), 32'd0);
    endtask

    initial begin
        int last_sof = -1;
        int de_cnt = 0;
        en = 1'b1;
        pix_valid = 1'b1;
        repeat (3) @(posedge pixel_clk);
        #1 check_idle("reset");
        #1 rst_n = 1'b1;

        repeat (3 * HT * VT + 20) begin
            step(1'b1, 1'b1, 1'b0);
            if (sof) begin
                if (last_sof >= 0) begin
                    chk("sof_period", 32'(cyc - last_sof), 32'(HT * VT));
                    chk("de_per_frame", 32'(de_cnt), 32'(HA * VA));
                end
                last_sof = cyc;
                de_cnt = 0;
            end
            if (de) de_cnt++;
        end

        run_to(3, 1);
        repeat (3) step(1'b1, 1'b0, 1'b0);
        repeat (20) step(1'b1, 1'b1, 1'b0);
        chk("underrun_held", 32'(underrun), 32'd1);
        step(1'b1, 1'b1, 1'b1);
        chk("underrun_cleared", 32'(underrun), 32'd0);

        run_to(2, 0);
        step(1'b1, 1'b0, 1'b1);
        chk("underrun_set_wins", 32'(underrun), 32'd1);
        step(1'b1, 1'b1, 1'b1);

        run_to(5, 2);
        repeat (50) step(1'b0, 1'b1, 1'b0);
        repeat (HT * VT + 10) step(1'b1, 1'b1, 1'b0);

        run_to(HA + HF + 1, 1);
        step(1'b1, 1'b1, 1'b0);
        chk("hsync_pre_reset", 32'(hsync), 32'd0);
        #2 rst_n = 1'b0;
        #1 check_idle("async_reset");
        m_h = 0;
        m_v = 0;
        m_run = 1'b0;
        m_sync = 0;
        m_und = 1'b0;
        repeat (2) @(posedge pixel_clk);
        #2 rst_n = 1'b1;
        repeat (HT * VT + 10) step(1'b1, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
